cache_mem_arbiter: RTL and testbench

//   Arbitrates the single 128-bit memory port between the instruction cache and data cache.

---
 rtl/cache_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares the single line-wide memory port between the I-cache and D-cache.
// One transaction is in flight at a time; its result is returned only if the owner still wants it.
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {SIDE_I, SIDE_D} side_t;

    state_t            state;
    state_t            state_next;
    side_t             owner;
    side_t             last_grant;
    side_t             grant_side;
    logic              grant;
    logic              done;
    logic              i_valid;
    logic              d_valid;
    logic              i_match;
    logic              d_match;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign i_valid = i_mem_read | i_mem_write;
    assign d_valid = d_mem_read | d_mem_write;

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round-robin only matters when both sides ask in the same IDLE cycle.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_side = SIDE_I;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid || d_valid) begin
                    grant      = 1'b1;
                    state_next = BUSY;
                    if (d_valid && (!i_valid || last_grant == SIDE_I)) begin
                        grant_side = SIDE_D;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A write request wins over a simultaneous read on the same side.
    assign sel_write = (grant_side == SIDE_D) ? d_mem_write : i_mem_write;
    assign sel_addr  = (grant_side == SIDE_D) ? d_mem_addr  : i_mem_addr;
    assign sel_wdata = (grant_side == SIDE_D) ? d_mem_wdata : i_mem_wdata;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner      <= SIDE_I;
            last_grant <= SIDE_I;
        end else if (grant) begin
            owner      <= grant_side;
            last_grant <= grant_side;
            mem_write  <= sel_write;
            mem_read   <= !sel_write;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
        end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // A prefetch that moved or vanished while in flight gets no ready; its data is dropped.
    assign i_match = i_valid && (i_mem_write == mem_write) && (i_mem_addr == mem_addr);
    assign d_match = d_valid && (d_mem_write == mem_write) && (d_mem_addr == mem_addr);

    assign i_mem_ready = done && !proc_reset && (owner == SIDE_I) && i_match;
    assign d_mem_ready = done && !proc_reset && (owner == SIDE_D) && d_match;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_cache_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk         = 1'b0;
    logic          proc_reset  = 1'b1;
    logic          i_mem_read  = 1'b0;
    logic          i_mem_write = 1'b0;
    logic [AW-1:0] i_mem_addr  = '0;
    logic [DW-1:0] i_mem_wdata = '0;
    logic          d_mem_read  = 1'b0;
    logic          d_mem_write = 1'b0;
    logic [AW-1:0] d_mem_addr  = '0;
    logic [DW-1:0] d_mem_wdata = '0;
    logic [DW-1:0] mem_rdata   = '0;
    logic          mem_ready   = 1'b0;
    logic [DW-1:0] i_mem_rdata;
    logic [DW-1:0] d_mem_rdata;
    logic          i_mem_ready;
    logic          d_mem_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int   vectors     = 0;
    int   miscompares = 0;
    int   mem_lat     = 4;
    int   mem_cnt     = 0;
    logic force_late  = 1'b0;

    int            i_ready_cnt  = 0;
    int            d_ready_cnt  = 0;
    int            read_cycles  = 0;
    logic          prev_strobe  = 1'b0;
    logic [DW-1:0] i_last_rdata = '0;
    logic [AW-1:0] log_addr[$];
    logic          log_write[$];

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Memory: completes mem_lat cycles after the strobe first appears; returns a tagged line.
    always @(posedge clk) begin
        #2;
        if (mem_read || mem_write) mem_cnt = mem_cnt + 1;
        else mem_cnt = 0;
        mem_ready = force_late || ((mem_read || mem_write) && mem_cnt == mem_lat);
        mem_rdata = mem_ready ? {4{{4'hA, mem_addr}}} : '0;
    end

    // Reference model: one outstanding transaction record and a round-robin memory.
    logic          i_req;
    logic          d_req;
    logic          m_busy   = 1'b0;
    logic          m_side_d = 1'b0;
    logic          m_last_d = 1'b0;
    logic          m_write  = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;

    assign i_req = i_mem_read | i_mem_write;
    assign d_req = d_mem_read | d_mem_write;

    function automatic logic pick_d(input logic iv, input logic dv, input logic last_d);
        return dv && (!iv || !last_d);
    endfunction

    always @(posedge clk) begin
        if (proc_reset) begin
            m_busy   <= 1'b0;
            m_side_d <= 1'b0;
            m_last_d <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else if (m_busy) begin
            if (mem_ready) m_busy <= 1'b0;
        end else if (i_req || d_req) begin
            m_busy   <= 1'b1;
            m_side_d <= pick_d(i_req, d_req, m_last_d);
            m_last_d <= pick_d(i_req, d_req, m_last_d);
            if (pick_d(i_req, d_req, m_last_d)) begin
                m_write <= d_mem_write;
                m_addr  <= d_mem_addr;
                m_wdata <= d_mem_wdata;
            end else begin
                m_write <= i_mem_write;
                m_addr  <= i_mem_addr;
                m_wdata <= i_mem_wdata;
            end
        end
    end

    function automatic logic exp_ready(input logic side_d);
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        rd = side_d ? d_mem_read  : i_mem_read;
        wr = side_d ? d_mem_write : i_mem_write;
        a  = side_d ? d_mem_addr  : i_mem_addr;
        return m_busy && mem_ready && !proc_reset && (m_side_d == side_d)
               && (rd || wr) && (wr == m_write) && (a == m_addr);
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, log grants, let requesters drop on ready.
    task automatic apply_stimulus();
        logic i_seen;
        logic d_seen;
        logic strobe;
        @(negedge clk);
        check_output("mem_read",    DW'(mem_read),    DW'(m_busy && !m_write));
        check_output("mem_write",   DW'(mem_write),   DW'(m_busy && m_write));
        check_output("mem_addr",    DW'(mem_addr),    DW'(m_addr));
        check_output("mem_wdata",   mem_wdata,        m_wdata);
        check_output("i_mem_ready", DW'(i_mem_ready), DW'(exp_ready(1'b0)));
        check_output("d_mem_ready", DW'(d_mem_ready), DW'(exp_ready(1'b1)));
        check_output("i_mem_rdata", i_mem_rdata,      mem_rdata);
        check_output("d_mem_rdata", d_mem_rdata,      mem_rdata);
        i_seen = i_mem_ready;
        d_seen = d_mem_ready;
        if (i_seen) begin
            i_ready_cnt++;
            i_last_rdata = i_mem_rdata;
        end
        if (d_seen) d_ready_cnt++;
        strobe = mem_read | mem_write;
        if (strobe && !prev_strobe) begin
            log_addr.push_back(mem_addr);
            log_write.push_back(mem_write);
        end
        prev_strobe = strobe;
        if (mem_read) read_cycles++;
        @(posedge clk);
        #1;
        if (i_seen) begin
            i_mem_read  = 1'b0;
            i_mem_write = 1'b0;
        end
        if (d_seen) begin
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
        end
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while ((i_mem_read || i_mem_write || d_mem_read || d_mem_write) && n < max) begin
            apply_stimulus();
            n++;
        end
        if (n >= max) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: requests still pending after %0d cycles", max);
        end
        apply_stimulus();
        apply_stimulus();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lstart;
        $display("[TB] reset with both sides requesting");
        i_mem_read = 1'b1;
        i_mem_addr = 28'h0000200;
        d_mem_read = 1'b1;
        d_mem_addr = 28'h0000100;
        apply_stimulus();
        apply_stimulus();
        check_output("reset mem_read",  DW'(mem_read),  DW'(1'b0));
        check_output("reset mem_write", DW'(mem_write), DW'(1'b0));
        check_output("reset mem_addr",  DW'(mem_addr),  DW'(0));
        proc_reset = 1'b0;
        apply_stimulus();
        check_output("first grant addr", DW'(mem_addr), DW'(28'h0000100));
        check_output("first grant read", DW'(mem_read), DW'(1'b1));
        wait_done(40);
        check_output("reset log0", DW'(log_addr[0]), DW'(28'h0000100));
        check_output("reset log1", DW'(log_addr[1]), DW'(28'h0000200));

        $display("[TB] single I read, latency 5");
        mem_lat = 5;
        read_cycles = 0;
        i_ready_cnt = 0;
        d_ready_cnt = 0;
        i_mem_read = 1'b1;
        i_mem_addr = 28'h0000010;
        wait_done(40);
        check_count("single read strobe cycles", read_cycles, 5);
        check_count("single i ready pulses", i_ready_cnt, 1);
        check_count("single d ready pulses", d_ready_cnt, 0);
        check_output("single rdata", i_last_rdata, 128'hA0000010_A0000010_A0000010_A0000010);

        $display("[TB] contention D write vs I read");
        mem_lat = 3;
        lstart = log_addr.size();
        for (int rep = 0; rep < 2; rep++) begin
            d_mem_write = 1'b1;
            d_mem_addr  = 28'h0000020;
            d_mem_wdata = 128'hDEADBEEF_00000020_12345678_9ABCDEF0;
            i_mem_read  = 1'b1;
            i_mem_addr  = 28'h0000030;
            wait_done(60);
        end
        check_count("contention grant count", log_addr.size() - lstart, 4);
        for (int k = 0; k < 4; k++) begin
            check_output("contention addr", DW'(log_addr[lstart + k]),
                         (k % 2 == 0) ? DW'(28'h0000020) : DW'(28'h0000030));
            check_output("contention op", DW'(log_write[lstart + k]), DW'(k % 2 == 0));
        end

        $display("[TB] stale prefetch");
        mem_lat = 6;
        i_ready_cnt = 0;
        lstart = log_addr.size();
        i_mem_read = 1'b1;
        i_mem_addr = 28'h0000040;
        apply_stimulus();
        apply_stimulus();
        i_mem_addr = 28'h0000044;
        apply_stimulus();
        apply_stimulus();
        check_output("stale held addr", DW'(mem_addr), DW'(28'h0000040));
        wait_done(60);
        check_count("stale i ready pulses", i_ready_cnt, 1);
        check_output("stale first txn", DW'(log_addr[lstart]), DW'(28'h0000040));
        check_output("stale retry txn", DW'(log_addr[lstart + 1]), DW'(28'h0000044));

        $display("[TB] D read+write together");
        mem_lat = 2;
        d_ready_cnt = 0;
        d_mem_read  = 1'b1;
        d_mem_write = 1'b1;
        d_mem_addr  = 28'h0000050;
        d_mem_wdata = 128'h55555555_00000050_AAAAAAAA_0F0F0F0F;
        apply_stimulus();
        check_output("rw write strobe", DW'(mem_write), DW'(1'b1));
        check_output("rw read strobe",  DW'(mem_read),  DW'(1'b0));
        check_output("rw wdata", mem_wdata, 128'h55555555_00000050_AAAAAAAA_0F0F0F0F);
        wait_done(40);
        check_count("rw d ready pulses", d_ready_cnt, 1);

        $display("[TB] reset mid-transaction and late memory ready");
        mem_lat = 10;
        i_ready_cnt = 0;
        d_ready_cnt = 0;
        i_mem_read = 1'b1;
        i_mem_addr = 28'h0000300;
        apply_stimulus();
        apply_stimulus();
        proc_reset = 1'b1;
        i_mem_read = 1'b0;
        apply_stimulus();
        check_output("mid reset strobe", DW'(mem_read), DW'(1'b0));
        proc_reset = 1'b0;
        apply_stimulus();
        apply_stimulus();
        force_late = 1'b1;
        apply_stimulus();
        force_late = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_count("abandoned i ready pulses", i_ready_cnt, 0);
        check_count("late ready d pulses", d_ready_cnt, 0);
        check_output("late ready strobe", DW'(mem_read), DW'(1'b0));
        mem_lat = 3;
        d_mem_read = 1'b1;
        d_mem_addr = 28'h0000060;
        wait_done(40);
        check_count("after late ready d pulses", d_ready_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
